// File: rtl/ras_circular.sv
// Circular return-address stack with power-of-two depth, a selectable full-stack policy,
// same-cycle push+pop replace, flush and a saturating lost-push counter.
module ras_circular #(
    parameter int unsigned VLEN             = 32,
    parameter int unsigned DEPTH            = 2,
    parameter int unsigned OVERWRITE_OLDEST = 1,
    parameter int unsigned DROP_CNT_W       = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [VLEN-1:0]            data_i,
    output logic                       top_valid_o,
    output logic [VLEN-1:0]            top_addr_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic [DROP_CNT_W-1:0]      drop_cnt_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    localparam logic [PW-1:0]         TP_ONE    = PW'(1);
    localparam logic [PW-1:0]         TP_ZERO   = {PW{1'b0}};
    localparam logic [CW-1:0]         CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]         CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0]         CNT_FULL  = CW'(DEPTH);
    localparam logic [DROP_CNT_W-1:0] DROP_ONE  = DROP_CNT_W'(1);
    localparam logic [DROP_CNT_W-1:0] DROP_SAT  = {DROP_CNT_W{1'b1}};
    localparam logic [DROP_CNT_W-1:0] DROP_ZERO = {DROP_CNT_W{1'b0}};

    logic [VLEN-1:0]       mem_q [DEPTH];
    logic [PW-1:0]         tp_q, tp_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;
    logic                  we_s;
    logic [PW-1:0]         waddr_s;
    logic                  empty_s;
    logic                  full_s;

    assign empty_s = (count_q == CNT_ZERO);
    assign full_s  = (count_q == CNT_FULL);

    // Next-state selection; flush dominates, then replace, then push, then pop.
    always_comb begin
        tp_d    = tp_q;
        count_d = count_q;
        drop_d  = drop_q;
        we_s    = 1'b0;
        waddr_s = tp_q;
        if (flush_i) begin
            tp_d    = TP_ZERO;
            count_d = CNT_ZERO;
        end else if (push_i && pop_i && !empty_s) begin
            we_s    = 1'b1;
            waddr_s = tp_q;
        end else if (push_i) begin
            if (!full_s) begin
                tp_d    = tp_q + TP_ONE;
                waddr_s = tp_q + TP_ONE;
                we_s    = 1'b1;
                count_d = count_q + CNT_ONE;
            end else begin
                if (drop_q != DROP_SAT) begin
                    drop_d = drop_q + DROP_ONE;
                end else begin
                    drop_d = drop_q;
                end
                // Wrapping onto the oldest slot keeps the newest DEPTH addresses.
                if (OVERWRITE_OLDEST != 0) begin
                    tp_d    = tp_q + TP_ONE;
                    waddr_s = tp_q + TP_ONE;
                    we_s    = 1'b1;
                end else begin
                    we_s    = 1'b0;
                end
            end
        end else if (pop_i) begin
            if (!empty_s) begin
                tp_d    = tp_q - TP_ONE;
                count_d = count_q - CNT_ONE;
            end else begin
                tp_d    = tp_q;
            end
        end else begin
            we_s = 1'b0;
        end
    end

    // Pointer, occupancy and lost-push counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tp_q    <= TP_ZERO;
            count_q <= CNT_ZERO;
            drop_q  <= DROP_ZERO;
        end else begin
            tp_q    <= tp_d;
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    // Entry storage; popped and flushed entries keep their contents.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= {VLEN{1'b0}};
            end
        end else if (we_s) begin
            mem_q[waddr_s] <= data_i;
        end else begin
            mem_q[waddr_s] <= mem_q[waddr_s];
        end
    end

    assign top_addr_o  = mem_q[tp_q];
    assign top_valid_o = !empty_s;
    assign count_o     = count_q;
    assign full_o      = full_s;
    assign drop_cnt_o  = drop_q;

endmodule
